mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Multi-cycle multiply engine and sequencer for the `OP_MULT` path in the EXE stage. The decode controller already routes `OP_MULT` to `EXE_MULT` with write-back disabled. This block runs a fixed-latency radix-2 shift-add multiply into dedicated HI/LO registers. While it runs, it drives a stall so the hazard logic holds IF/ID/EXE until the product is ready.

## Interface
Parameters:
- `WORD_LEN`, default `` `WORD_LEN `` (32): operand width; product is 2×`WORD_LEN`.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EXE holds a valid `EXE_MULT` instruction; stays high while stalled.
- `flush`  in  1  abort the in-flight multiply (branch/jump squash).
- `src1`  in  `WORD_LEN`  multiplicand, sampled only when a multiply is accepted.
- `src2`  in  `WORD_LEN`  multiplier, sampled only when a multiply is accepted.
- `stall`  out  1  freezes IF/ID/EXE; ORed into `hazard_detected`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; HI/LO are valid from this cycle.
- `hi`  out  `WORD_LEN`  upper product word (registered).
- `lo`  out  `WORD_LEN`  lower product word (registered).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If `start & ~flush`, latch operands, clear the accumulator, load the counter with `WORD_LEN`, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half with carry. Then shift the accumulator right by 1 and decrement the counter.
  - When the counter reaches 1, go to DONE and write `hi`/`lo` on that same edge.
  - `flush` in RUN: go to IDLE; `hi`/`lo` are left unchanged and `done` does not fire.
- DONE:
  - `done=1`, `stall=0`, so the pipeline advances the MULT out of EXE on this edge.
  - `start` is ignored here, because it still reflects the completing instruction.
  - Always go to IDLE.
- Latency is fixed regardless of operand values (zero operands take the full count).
- Arithmetic:
  - Accumulator is `2*WORD_LEN+1` bits, with the carry bit kept during the add.
  - Counter is `$clog2(WORD_LEN)+1` bits.
  - Result is exact modulo 2^(2·`WORD_LEN`).
- `stall = (IDLE & start & ~flush) | RUN`. This is combinational from state, so the MULT is frozen in the same cycle it is seen.
- Reset (any state, including mid-RUN): IDLE, `hi=0`, `lo=0`, accumulator=0, `done=0`, `busy=0`. Combinationally, `stall=0` after reset only when `start=0`; if `start=1` in the first cycle after reset, `stall=1`.
- Simultaneous `start` and `flush` in IDLE: `flush` wins; the multiply is not accepted.

## Timing
- Cycle 0: IDLE with `start` → `stall=1`; operands captured at the end of cycle 0.
- Cycles 1..`WORD_LEN`: RUN; `busy=1`, `stall=1`.
- Cycle `WORD_LEN`+1: DONE; `done=1`, `stall=0`, new `hi`/`lo` visible.
- Back-to-back MULTs: the second is accepted in cycle `WORD_LEN`+2, giving one bubble cycle.
- `hi`/`lo` hold their value until the next completed multiply.

## Configuration
- `MULT_SIGNED_EN` defined:
  - Operands are treated as two's complement.
  - Magnitudes are taken at acceptance.
  - The product is negated (2·`WORD_LEN`-bit) when the operand signs differ, applied on the RUN→DONE write.
  - Latency is unchanged.
- `MULT_SIGNED_EN` undefined: unsigned multiply only; the sign logic is absent.

## Structure
- State encodings `MSEQ_IDLE`, `MSEQ_RUN`, `MSEQ_DONE` go in `defines.v` next to the existing `` `WORD_LEN `` and `` `EXE_MULT ``. Reuse those; no new opcode.
- One sub-module, `mult_shift_add_dp`, holds the accumulator, add/shift step, and sign fix-up.
- `mult_sequencer` holds the FSM, the counter, the stall/done logic, and the HI/LO registers.

## Test plan
With `WORD_LEN`=32:
- `src1=3`, `src2=5`, `start` held → `stall` high in cycles 0–32, `done` in cycle 33, `hi=0`, `lo=15`.
- Unsigned `0xFFFFFFFF × 0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
- With `MULT_SIGNED_EN`:
  - `-1 × -1` → `hi=0`, `lo=1`.
  - `-3 × 7` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`.
- Prior product `hi=0`, `lo=15`; new multiply with `flush` asserted in cycle 10 → IDLE in cycle 11, no `done`, `hi=0`, `lo=15` retained.
- `rst` asserted mid-RUN (cycle 12) → next cycle IDLE, `hi=lo=0`, `busy=0`, `done=0`; `stall=0` if `start` is low.
- Two consecutive MULTs (`2×2`, then `4×4`) → `done` in cycles 33 and 67, `lo=4` then `lo=16`; `start` during DONE does not re-trigger.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// rtl/mult_sequencer_pkg.sv - shared width and FSM state encodings for the EXE-stage multiply sequencer
package mult_sequencer_pkg;

  localparam int MSEQ_WORD_LEN = 32;

  typedef enum logic [1:0] {
    MSEQ_IDLE = 2'd0,
    MSEQ_RUN  = 2'd1,
    MSEQ_DONE = 2'd2
  } mseq_state_e;

  function automatic int mseq_cnt_width(input int word_len);
    return $clog2(word_len) + 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - radix-2 shift-add accumulator with optional sign fix-up (MULT_SIGNED_EN)
// o_product is the value after the current step, so the sequencer can write HI/LO on the last edge.
module mult_shift_add_dp
  import mult_sequencer_pkg::*;
#(
  parameter int WORD_LEN = MSEQ_WORD_LEN
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic [WORD_LEN-1:0]     i_mcand,
  input  logic [WORD_LEN-1:0]     i_mplier,
  output logic [2*WORD_LEN-1:0]   o_product
);

  localparam int AW = 2*WORD_LEN + 1;

  logic [AW-1:0]         r_acc;
  logic [WORD_LEN-1:0]   r_mcand;
  logic [WORD_LEN:0]     w_upper_sum;
  logic [2*WORD_LEN-1:0] w_shifted;
  logic [WORD_LEN-1:0]   w_mcand_mag;
  logic [WORD_LEN-1:0]   w_mplier_mag;

  // Upper half plus carry bit; the top bit is always zero after a shift, so the sum cannot overflow.
  always_comb begin
    w_upper_sum = r_acc[AW-1:WORD_LEN];
    if (r_acc[0]) begin
      w_upper_sum = r_acc[AW-1:WORD_LEN] + {1'b0, r_mcand};
    end
    w_shifted = {w_upper_sum, r_acc[WORD_LEN-1:1]};
  end

`ifdef MULT_SIGNED_EN
  logic r_neg;

  always_comb begin
    w_mcand_mag  = i_mcand[WORD_LEN-1]  ? -i_mcand  : i_mcand;
    w_mplier_mag = i_mplier[WORD_LEN-1] ? -i_mplier : i_mplier;
    o_product    = r_neg ? -w_shifted : w_shifted;
  end
`else
  always_comb begin
    w_mcand_mag  = i_mcand;
    w_mplier_mag = i_mplier;
    o_product    = w_shifted;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
`ifdef MULT_SIGNED_EN
      r_neg   <= 1'b0;
`endif
    end else if (i_load) begin
      r_acc   <= {1'b0, {WORD_LEN{1'b0}}, w_mplier_mag};
      r_mcand <= w_mcand_mag;
`ifdef MULT_SIGNED_EN
      r_neg   <= i_mcand[WORD_LEN-1] ^ i_mplier[WORD_LEN-1];
`endif
    end else if (i_step) begin
      r_acc   <= {1'b0, w_shifted};
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - fixed-latency OP_MULT sequencer: FSM, step counter, stall/done and HI/LO registers
// Signed operation is selected with MULT_SIGNED_EN; the default build is unsigned.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WORD_LEN = MSEQ_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] src1,
  input  logic [WORD_LEN-1:0] src2,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo
);

  localparam int CNT_W = mseq_cnt_width(WORD_LEN);

  mseq_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [WORD_LEN-1:0]   r_hi;
  logic [WORD_LEN-1:0]   r_lo;
  logic                  w_accept;
  logic                  w_step;
  logic [2*WORD_LEN-1:0] w_product;

  // Stall must rise in the same cycle the MULT reaches EXE, hence combinational from state.
  assign w_accept = (r_state == MSEQ_IDLE) && start && !flush;
  assign w_step   = (r_state == MSEQ_RUN) && !flush;

  mult_shift_add_dp #(
    .WORD_LEN (WORD_LEN)
  ) u_dp (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_mcand   (src1),
    .i_mplier  (src2),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MSEQ_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MSEQ_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= MSEQ_RUN;
            r_cnt   <= CNT_W'(WORD_LEN);
            r_busy  <= 1'b1;
          end
        end
        MSEQ_RUN: begin
          if (flush) begin
            r_state <= MSEQ_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= MSEQ_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_hi    <= w_product[2*WORD_LEN-1:WORD_LEN];
              r_lo    <= w_product[WORD_LEN-1:0];
            end
          end
        end
        MSEQ_DONE: begin
          // start still belongs to the completing instruction, so it is not looked at here.
          r_state <= MSEQ_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= MSEQ_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stall = w_accept || (r_state == MSEQ_RUN);
  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer against an arithmetic product model
module tb_mult_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mult_sequencer #(.WORD_LEN(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .src1  (src1),
    .src2  (src2),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge (cycle 0); returns just after the edge that ends the DONE cycle.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int stall_cnt, output int last_stall,
                          output int busy_cnt, output logic [W-1:0] hi_o, output logic [W-1:0] lo_o,
                          output int start_cyc);
    src1 = a; src2 = b; start = 1'b1; flush = 1'b0;
    done_cyc = -1; stall_cnt = 0; last_stall = -1; busy_cnt = 0;
    hi_o = '0; lo_o = '0; start_cyc = cyc;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (stall) begin stall_cnt++; last_stall = c; end
      if (busy) busy_cnt++;
      if (done) begin done_cyc = c; hi_o = hi; lo_o = lo; end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; src1 = '0; src2 = '0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #1;
    n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    n_vec++; if ({busy, done, stall} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl busy/done/stall got %b want 000", {busy, done, stall}); end
    rst = 1'b1; next_cycle();
    rst = 1'b0; start = 1'b1; flush = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL start_flush_stall got %b want 0", stall); end
    flush = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_start_stall got %b want 1", stall); end
    start = 1'b0;
    next_cycle();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_flush_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int dc, sc, ls, bc, sy;
    logic [W-1:0] h, l;
    run_mult(32'd3, 32'd5, dc, sc, ls, bc, h, l, sy);
    start = 1'b0;
    n_vec++; if (dc !== W+1) begin n_err++; $display("FAIL basic_done_cycle got %0d want %0d", dc, W+1); end
    n_vec++; if (sc !== W+1 || ls !== W) begin n_err++; $display("FAIL basic_stall got count %0d last %0d want %0d/%0d", sc, ls, W+1, W); end
    n_vec++; if (bc !== W) begin n_err++; $display("FAIL basic_busy got %0d want %0d", bc, W); end
    n_vec++; if ({h, l} !== 64'd15) begin n_err++; $display("FAIL basic_product got %h want %h", {h, l}, 64'd15); end
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++; if ({busy, done, stall} !== 3'b000) begin n_err++; $display("FAIL basic_idle c%0d got %b want 000", c, {busy, done, stall}); end
      next_cycle();
    end
    n_vec++; if ({hi, lo} !== 64'd15) begin n_err++; $display("FAIL basic_hold got %h want 15", {hi, lo}); end
  endtask

  task automatic test_corners();
    logic [W-1:0] av [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000};
    logic [W-1:0] bv [4] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [2*W-1:0] want [4];
`ifdef MULT_SIGNED_EN
    want = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'h0, 64'h4000_0000_0000_0000};
`else
    want = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0006_FFFF_FFEB, 64'h0, 64'h4000_0000_0000_0000};
`endif
    for (int i = 0; i < 4; i++) begin
      int dc, sc, ls, bc, sy;
      logic [W-1:0] h, l;
      run_mult(av[i], bv[i], dc, sc, ls, bc, h, l, sy);
      start = 1'b0;
      n_vec++; if ({h, l} !== want[i]) begin n_err++; $display("FAIL corner%0d product got %h want %h", i, {h, l}, want[i]); end
      n_vec++; if (dc !== W+1) begin n_err++; $display("FAIL corner%0d latency got %0d want %0d", i, dc, W+1); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int dc, sc, ls, bc, sy;
      logic [W-1:0] a, b, h, l;
      logic [2*W-1:0] want;
      a = $urandom; b = $urandom;
      if (i % 7 == 3) a = '0;
      if (i % 5 == 4) b = $urandom_range(0, 3);
      want = ref_mul(a, b);
      run_mult(a, b, dc, sc, ls, bc, h, l, sy);
      start = 1'b0;
      n_vec++; if ({h, l} !== want || dc !== W+1) begin
        n_err++; $display("FAIL rand%0d %h*%h got %h at %0d want %h at %0d", i, a, b, {h, l}, dc, want, W+1);
      end
      if (i % 2 == 0) next_cycle();
    end
  endtask

  task automatic test_flush();
    int dc, sc, ls, bc, sy;
    int seen_done = 0;
    logic [W-1:0] h, l;
    run_mult(32'd3, 32'd5, dc, sc, ls, bc, h, l, sy);
    src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    for (int c = 0; c < 10; c++) next_cycle();
    flush = 1'b1; start = 1'b0;
    next_cycle();
    flush = 1'b0;
    #1;
    n_vec++; if ({busy, done, stall} !== 3'b000) begin n_err++; $display("FAIL flush_idle got %b want 000", {busy, done, stall}); end
    for (int c = 0; c < 40; c++) begin
      if (done) seen_done++;
      next_cycle();
    end
    n_vec++; if (seen_done !== 0) begin n_err++; $display("FAIL flush_no_done got %0d pulses want 0", seen_done); end
    n_vec++; if ({hi, lo} !== 64'd15) begin n_err++; $display("FAIL flush_hilo got %h want 15", {hi, lo}); end
  endtask

  task automatic test_reset_midrun();
    src1 = 32'd6; src2 = 32'd7; start = 1'b1;
    for (int c = 0; c < 12; c++) next_cycle();
    rst = 1'b1; start = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL midrst_hilo got %h want 0", {hi, lo}); end
    n_vec++; if ({busy, done, stall} !== 3'b000) begin n_err++; $display("FAIL midrst_ctrl got %b want 000", {busy, done, stall}); end
    for (int c = 0; c < 40; c++) begin
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done c%0d got 1 want 0", c); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, sc, ls, bc, s1, s2;
    logic [W-1:0] h1, l1, h2, l2;
    run_mult(32'd2, 32'd2, dc1, sc, ls, bc, h1, l1, s1);
    run_mult(32'd4, 32'd4, dc2, sc, ls, bc, h2, l2, s2);
    start = 1'b0;
    n_vec++; if (dc1 !== 33) begin n_err++; $display("FAIL b2b_done1 got %0d want 33", dc1); end
    n_vec++; if ((s2 - s1) + dc2 !== 67) begin n_err++; $display("FAIL b2b_done2 got %0d want 67", (s2 - s1) + dc2); end
    n_vec++; if ({h1, l1} !== 64'd4) begin n_err++; $display("FAIL b2b_first got %h want 4", {h1, l1}); end
    n_vec++; if ({h2, l2} !== 64'd16) begin n_err++; $display("FAIL b2b_second got %h want 16", {h2, l2}); end
    #1;
    n_vec++; if ({busy, stall} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got %b want 00", {busy, stall}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_flush();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
